// File: rtl/seg_scan_capture.sv
// seg_scan_capture: recovers hex nibbles from a multiplexed, active-low
// seven-segment display and publishes one packed frame per full scan.
module seg_scan_capture #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   dig_en_n,
  input  logic [6:0]              seg_n,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] frame_value,
  output logic [NUM_DIGITS-1:0]   frame_err
);

  localparam int unsigned     CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } state_e;

  logic [NUM_DIGITS-1:0]   en_meta_q, en_sync_q, en_prev_q;
  logic [6:0]              seg_meta_q, seg_sync_q, seg_prev_q;
  logic [6:0]              seg_code;
  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    sample_valid, sample_same, capture, frame_full;
  logic [3:0]              dec_val;
  logic                    dec_err;
  logic [NUM_DIGITS-1:0]   cap_oh, mask_q, mask_d;
  logic [NUM_DIGITS-1:0]   slot_err_q, frame_err_q;
  logic [4*NUM_DIGITS-1:0] slot_val_q, frame_value_q;
  logic                    frame_valid_q;

  // Two-flop synchronizer plus the previous synchronized sample; reset to
  // the inactive (all-high) level so no digit appears strobed after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_meta_q  <= '1;
      en_sync_q  <= '1;
      en_prev_q  <= '1;
      seg_meta_q <= '1;
      seg_sync_q <= '1;
      seg_prev_q <= '1;
    end else begin
      en_meta_q  <= dig_en_n;
      en_sync_q  <= en_meta_q;
      en_prev_q  <= en_sync_q;
      seg_meta_q <= seg_n;
      seg_sync_q <= seg_meta_q;
      seg_prev_q <= seg_sync_q;
    end
  end

  assign sample_valid = $onehot(~en_sync_q);
  assign sample_same  = (en_sync_q == en_prev_q) && (seg_sync_q == seg_prev_q);
  assign seg_code     = ~seg_sync_q;

  // Segment pattern (active-high gfedcba) to hex nibble; anything else is an error.
  always_comb begin
    dec_val = 4'h0;
    dec_err = 1'b0;
    case (seg_code)
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
      default: dec_err = 1'b1;
    endcase
  end

  // FSM state and stability counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: count identical valid samples, capture on the STABLE_CYCLES-th.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          state_d = TRACK;
          cnt_d   = CW'(1);
        end
      end
      TRACK: begin
        if (!sample_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!sample_same) begin
          cnt_d = CW'(1);
        end else begin
          // cnt_q stays below CNT_MAX in TRACK, so this increment cannot wrap.
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CNT_MAX) begin
            state_d = HELD;
            capture = 1'b1;
          end
        end
      end
      HELD: begin
        if (!sample_same) begin
          if (sample_valid) begin
            state_d = TRACK;
            cnt_d   = CW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A full mask publishes this cycle; a concurrent capture seeds the fresh mask.
  always_comb begin
    cap_oh     = capture ? ~en_sync_q : '0;
    frame_full = &mask_q;
    mask_d     = frame_full ? cap_oh : (mask_q | cap_oh);
  end

  // Slot storage, completion mask and published frame registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q        <= '0;
      slot_val_q    <= '0;
      slot_err_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_value_q <= '0;
      frame_err_q   <= '0;
    end else begin
      mask_q        <= mask_d;
      frame_valid_q <= frame_full;
      if (frame_full) begin
        frame_value_q <= slot_val_q;
        frame_err_q   <= slot_err_q;
      end
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (cap_oh[k]) begin
          slot_val_q[4*k +: 4] <= dec_val;
          slot_err_q[k]        <= dec_err;
        end
      end
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_value = frame_value_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture (4 digits, 4 stable samples).
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  dig_en_n;
  logic [6:0]  seg_n;
  logic        frame_valid;
  logic [15:0] frame_value;
  logic [3:0]  frame_err;

  seg_scan_capture #(
    .NUM_DIGITS   (4),
    .STABLE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dig_en_n   (dig_en_n),
    .seg_n      (seg_n),
    .frame_valid(frame_valid),
    .frame_value(frame_value),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][6:0] seg;   // seg_n per digit, [3] = digit3
    logic [15:0]     val;
    logic [3:0]      err;
  } vec_t;

  vec_t        vecs [6];
  logic [19:0] sb [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pulses = 0;
  int          last_pulse = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance n cycles, sampling outputs on the falling edge; each pulse is
  // matched against the oldest expected frame in the scoreboard.
  task automatic run(input int n);
    logic [19:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (frame_valid === 1'b1) begin
        pulses++;
        last_pulse = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse actual value=%h err=%b expected=no pulse",
                   frame_value, frame_err);
        end else begin
          e = sb.pop_front();
          check("frame_value", {16'h0, frame_value}, {16'h0, e[19:4]});
          check("frame_err", {28'h0, frame_err}, {28'h0, e[3:0]});
        end
      end
    end
  endtask

  task automatic strobe(input int d, input logic [6:0] s, input int n);
    dig_en_n = ~(4'(1) << d);
    seg_n    = s;
    run(n);
  endtask

  task automatic idle(input int n);
    dig_en_n = '1;
    seg_n    = '1;
    run(n);
  endtask

  initial begin
    int t0;
    int p0;

    vecs[0] = '{seg: {7'h79, 7'h24, 7'h30, 7'h19}, val: 16'h1234, err: 4'b0000};
    vecs[1] = '{seg: {7'h79, 7'h24, 7'h7F, 7'h19}, val: 16'h1204, err: 4'b0010};
    vecs[2] = '{seg: {7'h40, 7'h78, 7'h00, 7'h0E}, val: 16'h078F, err: 4'b0000};
    vecs[3] = '{seg: {7'h08, 7'h03, 7'h46, 7'h21}, val: 16'hABCD, err: 4'b0000};
    vecs[4] = '{seg: {7'h06, 7'h0E, 7'h10, 7'h12}, val: 16'hEF95, err: 4'b0000};
    vecs[5] = '{seg: {7'h79, 7'h55, 7'h24, 7'h7F}, val: 16'h1020, err: 4'b0101};

    // Reset state
    rst_n    = 1'b0;
    dig_en_n = '1;
    seg_n    = '1;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'h0, frame_valid}, 32'h0);
    check("rst_value", {16'h0, frame_value}, 32'h0);
    check("rst_err", {28'h0, frame_err}, 32'h0);
    rst_n = 1'b1;
    idle(5);

    // Table of full frames, digits strobed 3..0 for 10 cycles each
    for (int r = 0; r < 6; r++) begin
      sb.push_back({vecs[r].val, vecs[r].err});
      for (int d = 3; d >= 0; d--) strobe(d, vecs[r].seg[d], 10);
    end
    idle(5);

    // Pin-to-frame_valid latency of the last digit
    sb.push_back({16'h1234, 4'b0000});
    strobe(3, 7'h79, 10);
    strobe(2, 7'h24, 10);
    strobe(1, 7'h30, 10);
    t0 = cyc;
    strobe(0, 7'h19, 10);
    check("latency", last_pulse - t0, 7);
    idle(5);

    // Short glitch on digit2 must not be captured
    sb.push_back({16'h1834, 4'b0000});
    strobe(3, 7'h79, 10);
    strobe(2, 7'h24, 3);
    strobe(2, 7'h00, 10);
    strobe(1, 7'h30, 10);
    strobe(0, 7'h19, 10);
    idle(5);

    // Invalid enables after a partial frame: nothing may complete it
    strobe(3, 7'h79, 10);
    strobe(2, 7'h24, 10);
    strobe(1, 7'h30, 10);
    p0 = pulses;
    dig_en_n = 4'b1100;
    seg_n    = 7'h19;
    run(20);
    dig_en_n = 4'b1111;
    run(20);
    check("invalid_en_pulses", pulses - p0, 0);
    sb.push_back({16'h1234, 4'b0000});
    strobe(0, 7'h19, 10);
    idle(5);

    // Overwrite of digit0 before the frame completes
    sb.push_back({16'h1235, 4'b0000});
    strobe(0, 7'h19, 10);
    idle(5);
    strobe(0, 7'h12, 10);
    strobe(1, 7'h30, 10);
    strobe(2, 7'h24, 10);
    strobe(3, 7'h79, 10);
    idle(5);

    // Asynchronous reset mid-frame discards the partial frame
    strobe(3, 7'h79, 10);
    strobe(2, 7'h24, 10);
    #2;
    rst_n    = 1'b0;
    dig_en_n = '1;
    seg_n    = '1;
    #1;
    check("async_rst_valid", {31'h0, frame_valid}, 32'h0);
    check("async_rst_value", {16'h0, frame_value}, 32'h0);
    check("async_rst_err", {28'h0, frame_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses;
    strobe(1, 7'h30, 10);
    strobe(0, 7'h19, 10);
    check("post_rst_pulses", pulses - p0, 0);
    sb.push_back({16'h6534, 4'b0000});
    strobe(3, 7'h02, 10);
    strobe(2, 7'h12, 10);
    idle(10);

    check("frames_outstanding", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
